lifo_rd_stream: RTL and testbench



---
 rtl/lifo_rd_stream.sv | 181 ++++++++++++++++++
 tb/tb_lifo_rd_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lifo_rd_stream.sv
// Drains a requested number of words from an attached LIFO and presents them as a
// valid/ready stream, with a two-entry skid buffer that keeps full throughput.
module lifo_rd_stream #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,
    input  logic [AWIDTH:0]   len_i,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [AWIDTH:0]   count_o,
    output logic              short_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [AWIDTH:0] CNT_ZERO = '0;
    localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);

    state_t            state_reg, state_next;
    logic [AWIDTH:0]   remaining_reg, remaining_next;
    logic [AWIDTH:0]   xfer_cnt_reg, xfer_cnt_next;
    logic              short_pend_reg, short_pend_next;
    logic              done_reg, done_next;
    logic [AWIDTH:0]   count_reg, count_next;
    logic              short_reg, short_next;

    // The in-flight read occupies a buffer credit; its data is on lifo_q_i this cycle.
    logic              inflight_reg;
    logic              inflight_last_reg;

    logic [DWIDTH-1:0] buf_data_reg [2];
    logic [1:0]        buf_last_reg;
    logic [1:0]        buf_cnt_reg, buf_cnt_next;
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;

    logic [AWIDTH:0]   target;
    logic              credit_ok;
    logic              rdreq;
    logic              rd_last;
    logic              head_from_buf;
    logic              head_valid;
    logic [DWIDTH-1:0] head_data;
    logic              head_last;
    logic              pop;
    logic              pop_buf;
    logic              push;

    // Datapath: skid buffer head selection and credit accounting.
    always_comb begin
        target        = (len_i != CNT_ZERO) ? len_i : lifo_usedw_i;
        credit_ok     = (buf_cnt_reg + {1'b0, inflight_reg}) < 2'd2;
        rdreq         = (state_reg == ST_DRAIN) && (remaining_reg != CNT_ZERO) &&
                        !lifo_empty_i && credit_ok;
        rd_last       = rdreq && ((remaining_reg == CNT_ONE) || (lifo_usedw_i == CNT_ONE));
        head_from_buf = (buf_cnt_reg != 2'd0);
        head_valid    = head_from_buf || inflight_reg;
        head_data     = head_from_buf ? buf_data_reg[rd_ptr_reg] : lifo_q_i;
        head_last     = head_from_buf ? buf_last_reg[rd_ptr_reg] : inflight_last_reg;
        pop           = head_valid && ready_i;
        pop_buf       = pop && head_from_buf;
        // An in-flight word consumed straight off lifo_q_i never enters the buffer.
        push          = inflight_reg && !(pop && !head_from_buf);
        buf_cnt_next  = buf_cnt_reg + {1'b0, push} - {1'b0, pop_buf};
    end

    // Control: drain sequencing and completion reporting.
    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        xfer_cnt_next   = xfer_cnt_reg + (AWIDTH+1)'(pop);
        short_pend_next = short_pend_reg;
        done_next       = 1'b0;
        count_next      = count_reg;
        short_next      = short_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_i) begin
                    if (target == CNT_ZERO) begin
                        done_next  = 1'b1;
                        count_next = CNT_ZERO;
                        short_next = 1'b0;
                    end else begin
                        state_next      = ST_DRAIN;
                        remaining_next  = target;
                        xfer_cnt_next   = CNT_ZERO;
                        short_pend_next = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (rdreq) begin
                    remaining_next = remaining_reg - CNT_ONE;
                    if (rd_last) begin
                        state_next      = ST_FLUSH;
                        short_pend_next = (remaining_reg != CNT_ONE);
                    end
                end else if (lifo_empty_i && (remaining_reg != CNT_ZERO)) begin
                    state_next      = ST_FLUSH;
                    short_pend_next = 1'b1;
                end
            end
            ST_FLUSH: begin
                if ((buf_cnt_reg == 2'd0) && !inflight_reg) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                    count_next = xfer_cnt_reg;
                    short_next = short_pend_reg;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg         <= ST_IDLE;
            remaining_reg     <= '0;
            xfer_cnt_reg      <= '0;
            short_pend_reg    <= 1'b0;
            done_reg          <= 1'b0;
            count_reg         <= '0;
            short_reg         <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            buf_cnt_reg       <= 2'd0;
            wr_ptr_reg        <= 1'b0;
            rd_ptr_reg        <= 1'b0;
            buf_last_reg      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_data_reg[i] <= '0;
            end
        end else begin
            state_reg         <= state_next;
            remaining_reg     <= remaining_next;
            xfer_cnt_reg      <= xfer_cnt_next;
            short_pend_reg    <= short_pend_next;
            done_reg          <= done_next;
            count_reg         <= count_next;
            short_reg         <= short_next;
            inflight_reg      <= rdreq;
            inflight_last_reg <= rd_last;
            buf_cnt_reg       <= buf_cnt_next;
            if (push) begin
                buf_data_reg[wr_ptr_reg] <= lifo_q_i;
                buf_last_reg[wr_ptr_reg] <= inflight_last_reg;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop_buf) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign lifo_rdreq_o = rdreq;
    assign valid_o      = head_valid;
    assign data_o       = head_valid ? head_data : '0;
    assign last_o       = head_valid && head_last;
    assign busy_o       = (state_reg != ST_IDLE);
    assign done_o       = done_reg;
    assign count_o      = count_reg;
    assign short_o      = done_reg && short_reg;

endmodule

// File: tb/tb_lifo_rd_stream.sv
// Directed and randomized drains of lifo_rd_stream against a behavioural LIFO and a
// reference stack holding the words every drain is expected to deliver.
module tb_lifo_rd_stream;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk_i_tb = 1'b0;
    always #5 clk_i_tb = ~clk_i_tb;

    logic          arstn = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          ready = 1'b0;
    logic          rdreq;
    logic [DW-1:0] data;
    logic          valid, last, busy, done, short_f, empty;
    logic [AW:0]   count, usedw;

    // Behavioural LIFO: registered read data, one word per accepted rdreq.
    logic [DW-1:0] lifo_mem [256];
    logic [9:0]    lifo_sp = '0;
    logic [DW-1:0] lifo_q = '0;
    logic          push_en = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [9:0]    lifo_top;

    assign empty    = (lifo_sp == 10'd0);
    assign usedw    = lifo_sp[AW:0];
    assign lifo_top = lifo_sp - 10'd1;

    always @(posedge clk_i_tb) begin
        if (push_en) begin
            lifo_mem[lifo_sp[7:0]] <= push_data;
            lifo_sp                <= lifo_sp + 10'd1;
        end else if (rdreq && !empty) begin
            lifo_q  <= lifo_mem[lifo_top[7:0]];
            lifo_sp <= lifo_top;
        end
    end

    lifo_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i        (clk_i_tb),
        .arstn_i      (arstn),
        .start_i      (start),
        .len_i        (len),
        .lifo_rdreq_o (rdreq),
        .lifo_q_i     (lifo_q),
        .lifo_empty_i (empty),
        .lifo_usedw_i (usedw),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last),
        .busy_o       (busy),
        .done_o       (done),
        .count_o      (count),
        .short_o      (short_f)
    );

    logic [DW-1:0] ref_stack [$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i_tb);
            push_en   = 1'b1;
            push_data = DW'($urandom);
            ref_stack.push_back(push_data);
        end
        @(negedge clk_i_tb);
        push_en = 1'b0;
    endtask

    task automatic run_drain(input int l, input bit rnd_ready, input string tag);
        logic [DW-1:0] exp_q [$];
        int  target, n, k, issued, xfer, first_c, last_c;
        bit  exp_short, got_done, prev_stall;
        logic [DW-1:0] prev_data;
        logic prev_last;
        target    = (l != 0) ? l : ref_stack.size();
        n         = (target < ref_stack.size()) ? target : ref_stack.size();
        exp_short = (target > ref_stack.size());
        for (int i = 0; i < n; i++) exp_q.push_back(ref_stack.pop_back());
        k = 0; issued = 0; xfer = 0; first_c = 0; last_c = 0;
        got_done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        @(negedge clk_i_tb);
        start = 1'b1;
        len   = (AW+1)'(l);
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk_i_tb);
            start = 1'b0;
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (c == 0 && n > 0) check({tag, "_rdreq_latency"}, rdreq, 1);
            if (c == 1 && n > 0) check({tag, "_valid_latency"}, valid, 1);
            if (n == 0) check({tag, "_no_rdreq"}, rdreq, 0);
            if (prev_stall) begin
                check({tag, "_stall_valid"}, valid, 1);
                check({tag, "_stall_data"}, data, prev_data);
                check({tag, "_stall_last"}, last, prev_last);
            end
            issued += int'(rdreq);
            check({tag, "_outstanding"}, 32'(issued - xfer <= 2), 1);
            if (valid && ready) begin
                if (k < n) begin
                    check({tag, "_data"}, data, exp_q[k]);
                    check({tag, "_last"}, last, 32'(k == n - 1));
                end else begin
                    check({tag, "_extra_word"}, k, n);
                end
                if (k == 0) first_c = c;
                last_c = c;
                k++;
                xfer++;
            end
            prev_stall = valid && !ready;
            prev_data  = data;
            prev_last  = last;
            if (done) begin
                got_done = 1'b1;
                check({tag, "_count"}, count, n);
                check({tag, "_short"}, short_f, exp_short);
                check({tag, "_words"}, k, n);
                check({tag, "_busy_at_done"}, busy, 0);
            end
        end
        check({tag, "_done_seen"}, got_done, 1);
        if (!rnd_ready && n > 0) check({tag, "_burst_span"}, last_c - first_c, n - 1);
        @(negedge clk_i_tb);
        #1;
        check({tag, "_done_pulse"}, done, 0);
        $display("drain %s: len=%0d target=%0d words=%0d count=%0d", tag, l, target, k, count);
    endtask

    initial begin
        int k;
        #2 arstn = 1'b0;
        #1;
        check("rst_ctrl", {rdreq, valid, last, busy, done, short_f}, 0);
        check("rst_data", data, 0);
        check("rst_count", count, 0);
        repeat (2) @(negedge clk_i_tb);
        arstn = 1'b1;
        #1;
        check("idle_busy", busy, 0);

        run_drain(5, 1'b0, "empty_len5");
        run_drain(0, 1'b0, "empty_len0");

        fill(256);
        run_drain(0, 1'b0, "full256");
        check("full256_lifo_empty", empty, 1);

        fill(10);
        run_drain(4, 1'b0, "len4_of10");
        run_drain(0, 1'b1, "rest6");

        fill(3);
        run_drain(8, 1'b0, "len8_of3");

        fill(20);
        run_drain(20, 1'b1, "len20_rnd");

        // Abort a drain with reset after three transfers.
        fill(8);
        @(negedge clk_i_tb);
        start = 1'b1;
        len   = (AW+1)'(8);
        k     = 0;
        for (int c = 0; c < 40 && k < 3; c++) begin
            @(negedge clk_i_tb);
            start = 1'b0;
            ready = 1'b1;
            #1;
            if (valid && ready) begin
                check("abort_data", data, ref_stack[ref_stack.size() - 1 - k]);
                k++;
            end
        end
        check("abort_pre_words", k, 3);
        @(negedge clk_i_tb);
        arstn = 1'b0;
        #1;
        check("abort_rst_ctrl", {rdreq, valid, last, busy, done, short_f}, 0);
        check("abort_rst_data", data, 0);
        check("abort_rst_count", count, 0);
        @(negedge clk_i_tb);
        arstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i_tb);
            #1;
            check("abort_no_done", {done, valid, busy}, 0);
        end
        while (ref_stack.size() > int'(lifo_sp)) void'(ref_stack.pop_back());
        $display("drain abort: words before reset=%0d, lifo left=%0d", k, lifo_sp);
        run_drain(0, 1'b1, "post_reset");

        for (int r = 0; r < 6; r++) begin
            fill($urandom_range(0, 25));
            run_drain($urandom_range(0, 30), 1'b1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
